// File: rtl/stack_pop_ctrl.sv
// ---------------------------------------------------------------------------
// stack_pop_ctrl
//
// Pop-side controller for the LIFO register-file stack. A `start` command
// either pops `burst_len` entries or, with `burst_len` == 0, drains the stack
// until it reports empty. Popped words pass through a 2-entry output buffer
// onto a valid/ready stream. The stack may silently drop a pop that lands on
// the same cycle as an upstream push; such a pop is simply re-issued.
//
// Optional feature macro: STACK_POP_CTRL_ERR_EN
//   defined   : `err` is a sticky flag raised by a stk_valid with no pop
//               outstanding, or by a stk_valid that finds the buffer full.
//   undefined : `err` is tied low and no check logic exists.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   begin a burst (sampled in IDLE only)
//   burst_len     in   entries to pop, 0 = drain until empty
//   busy          out  high while in RUN or DRAIN
//   done          out  one-cycle pulse in the first IDLE cycle after a burst
//   stk_pop       out  pop request to the stack
//   stk_empty     in   stack empty flag
//   stk_valid     in   pop data valid, one cycle after an accepted pop
//   stk_pop_data  in   pop data
//   out_valid     out  output stream valid
//   out_ready     in   output stream ready
//   out_data      out  output stream data (buffer head)
//   err           out  sticky protocol error
//   state_dbg     out  current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a word moves on the output stream in every cycle where
// out_valid && out_ready at the rising edge. While out_valid is high and
// out_ready is low, out_valid and out_data hold their values.
// ---------------------------------------------------------------------------
module stack_pop_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             stk_pop,
    input  logic             stk_empty,
    input  logic             stk_valid,
    input  logic [N-1:0]     stk_pop_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rem_q;
    logic             mode_drain_q;
    logic             inflight_q;
    logic [1:0]       occ_q;
    logic [N-1:0]     buf0_q;
    logic [N-1:0]     buf1_q;
    logic             done_q;

    logic             deq;
    logic [1:0]       occ_left;
    logic [1:0]       pending;
    logic             rem_ok;
    logic             issue_ok;
    logic             enq;
    logic             load;
    logic             pop;

    // ------------------------------------------------------------------
    // Buffer bookkeeping
    // ------------------------------------------------------------------
    assign deq      = (occ_q != 2'd0) && out_ready;
    // Occupancy after this cycle's dequeue; deq implies occ_q >= 1.
    assign occ_left = occ_q - {1'b0, deq};
    // Words that will sit in the buffer once the outstanding pop (if any)
    // returns. A new pop only goes out if its word is guaranteed a slot.
    assign pending  = occ_left + {1'b0, inflight_q};
    // In burst mode the outstanding pop already accounts for one of the
    // remaining words, so only issue while more are still owed.
    assign rem_ok   = mode_drain_q || (rem_q > {{(CNT_W-1){1'b0}}, inflight_q});
    assign issue_ok = !stk_empty && (pending < 2'd2) && rem_ok;
    // A word arriving at a full buffer is discarded.
    assign enq      = stk_valid && (occ_left != 2'd2);

    // ------------------------------------------------------------------
    // FSM next state and pop request
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                pop = issue_ok;
                // Leave only once nothing is outstanding, so a dropped pop
                // always gets its chance to be re-issued.
                if (!inflight_q && !issue_ok &&
                    (mode_drain_q ? stk_empty : (rem_q == '0))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ_left == 2'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            mode_drain_q <= 1'b0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= pop;
            done_q     <= (state_q == S_DRAIN) && (state_d == S_IDLE);
            if (load) begin
                rem_q        <= burst_len;
                mode_drain_q <= (burst_len == '0);
            end else if (stk_valid && !mode_drain_q && (rem_q != '0)) begin
                // A dropped pop produces no stk_valid, so rem is untouched.
                rem_q <= rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output buffer, buf0 is the head
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            occ_q <= occ_left + {1'b0, enq};
            // New word lands in the first free slot after the dequeue shift.
            if (enq && (occ_left == 2'd0)) begin
                buf0_q <= stk_pop_data;
            end else if (deq) begin
                buf0_q <= buf1_q;
            end
            if (enq && (occ_left == 2'd1)) begin
                buf1_q <= stk_pop_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional protocol error flag
    // ------------------------------------------------------------------
`ifdef STACK_POP_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (stk_valid && (!inflight_q || (occ_left == 2'd2))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign stk_pop   = pop;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;
    assign state_dbg = state_q;

endmodule
